clk_div_monitor: RTL and testbench
==================================

Name: clk_div_monitor

Overview:
- Receiving end of a divided clock: takes a slow clock produced by the divider chain (e.g. divide-by-4 from the PLL area) as a plain data signal in the fast clk_in domain.
- Synchronizes it and produces single-cycle rise/fall clock-enable strobes for fast-domain logic.
- Measures the slow-clock period in clk_in cycles and asserts lock once the period matches the expected ratio; flags loss of lock.

Parameters:
- CNT_W, 8, width of period counter and period output.
- EXP_PERIOD, 4, expected slow-clock period in clk_in cycles.
- TOL, 0, allowed absolute deviation of a measured period from EXP_PERIOD.
- LOCK_CNT, 4, consecutive in-tolerance periods required to assert locked (1..15).

Ports:
- clk_in  input  1  fast clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- div_in  input  1  divided clock, treated as asynchronous data.
- rise_pulse  output  1  one-cycle strobe per div_in rising edge.
- fall_pulse  output  1  one-cycle strobe per div_in falling edge.
- period  output  CNT_W  last measured rise-to-rise period in clk_in cycles.
- period_valid  output  1  one-cycle strobe when period updates.
- locked  output  1  level; period stable within tolerance.
- err  output  1  one-cycle strobe on loss of lock.

Behaviour:
- Reset (async assert, sync release): all outputs 0, sync flops 0, counter 0, match count 0, FSM IDLE.
- Sync: sync1 <= div_in, sync2 <= sync1, sync3 <= sync2.
- rise_pulse <= sync2 & ~sync3; fall_pulse <= ~sync2 & sync3. Both are registered.
- Latency: div_in first sampled high at edge t -> rise_pulse high in the cycle after edge t+2. Same latency for fall.
- Counter cnt: loads 1 on an internal rise (sync2 & ~sync3); otherwise increments, saturating at 2^CNT_W-1 with no wrap.
- On an internal rise in MEASURE or LOCKED: period <= cnt, and period_valid pulses with rise_pulse.
- In-tolerance check: match = (period_new >= EXP_PERIOD-TOL) && (period_new <= EXP_PERIOD+TOL). Compare at CNT_W+1 bits so the subtraction cannot underflow.
- Timeout: cnt reaches 2*(EXP_PERIOD+TOL)+1 with no rise. Evaluated only in MEASURE and LOCKED.
- FSM IDLE:
  - No period known; the counter runs but is ignored.
  - First internal rise -> MEASURE, counter loads 1, no period_valid.
- FSM MEASURE:
  - Rise with match: match_cnt++. When match_cnt reaches LOCK_CNT -> LOCKED, locked <= 1 in the same cycle as that period_valid.
  - Rise without match: match_cnt <= 0, stay.
  - Timeout -> IDLE, match_cnt <= 0. No err, because lock was never held.
- FSM LOCKED:
  - Rise with match: stay.
  - Rise without match: err pulse, locked <= 0, match_cnt <= 0 -> MEASURE. The new period is still published.
  - Timeout (stopped clock): err pulse, locked <= 0 -> IDLE.
- Saturation: with CNT_W too small for the timeout value, a saturated cnt still triggers timeout (>= compare).
- Edge spacing: simultaneous rise and fall in one cycle is impossible by construction. div_in toggling every clk_in cycle yields alternating rise/fall pulses and period 2.
- Reset mid-operation: immediate return to IDLE. locked and all pulses drop asynchronously.

Decomposition:
- Package clk_div_mon_pkg:
  - FSM state typedef (IDLE, MEASURE, LOCKED; 2-bit encoding).
  - Localparam helpers: timeout threshold, match_cnt width = 4.
- One sub-module: sync_2ff (2-flop synchronizer with async active-low reset). Reusable elsewhere in the codebase.
- Edge detect, counter and FSM stay in the top.

Test Plan:
- Reset, then a div-by-4 div_in (2 high/2 low in clk_in cycles) -> rise_pulse every 4 cycles, 3 cycles after first high sample; period = 4 on each period_valid; locked rises on the 4th valid period (5th rise overall).
- Locked, then one period stretched to 6 cycles -> err single pulse, locked = 0, period = 6, then relock after 4 more good periods.
- Locked, then div_in held low -> err pulse and locked = 0 when cnt hits 9 (EXP 4, TOL 0), FSM returns to IDLE.
- TOL = 1, alternating periods of 3 and 5 cycles -> locked after 4 periods, no err.
- Divider toggling every cycle (period 2) -> rise/fall pulses alternate every cycle, period = 2, locked stays 0.
- Assert rst_n mid-LOCKED -> locked, period, period_valid, pulses all 0 immediately; after release, behaves as from first reset.

Source files
------------

// File: rtl/clk_div_mon_pkg.sv
// ----------------------------------------------------------------
// clk_div_mon_pkg: shared types and thresholds for clk_div_monitor
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package clk_div_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int MATCH_W = 4;

  // No rise by twice the longest acceptable period means the slow clock has stopped.
  function automatic int timeout_thr(input int exp_p, input int tol);
    return 2 * (exp_p + tol) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------
// sync_2ff: two-flop synchronizer, async active-low reset
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_div_monitor.sv
// ----------------------------------------------------------------
// clk_div_monitor: divided-clock sync, edge strobes, period lock
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 4,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             div_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err
);

  localparam logic [31:0]        TIMEOUT_U = 32'(timeout_thr(EXP_PERIOD, TOL));
  localparam int                 LO_I      = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
  localparam logic [CNT_W:0]     LO        = (CNT_W + 1)'(LO_I);
  localparam logic [CNT_W:0]     HI        = (CNT_W + 1)'(EXP_PERIOD + TOL);
  localparam logic [MATCH_W-1:0] LOCK_TGT  = MATCH_W'(LOCK_CNT);

  logic               sync2;
  logic               sync3;
  logic               rise_int;
  logic               fall_int;
  logic [CNT_W-1:0]   cnt;
  logic               match;
  logic               timeout;

  state_t             state, state_n;
  logic [MATCH_W-1:0] match_cnt, match_cnt_n;
  logic               locked_n;
  logic               err_n;
  logic [CNT_W-1:0]   period_n;
  logic               valid_n;

  sync_2ff u_sync (
    .clk   (clk_in),
    .rst_n (rst_n),
    .d     (div_in),
    .q     (sync2)
  );

  assign rise_int = sync2 & ~sync3;
  assign fall_int = ~sync2 & sync3;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync3      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      cnt        <= '0;
    end else begin
      sync3      <= sync2;
      rise_pulse <= rise_int;
      fall_pulse <= fall_int;
      if (rise_int)
        cnt <= CNT_W'(1);
      else if (cnt != '1)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // A saturated counter counts as a timeout even when the threshold exceeds its range.
  assign match   = ({1'b0, cnt} >= LO) && ({1'b0, cnt} <= HI);
  assign timeout = (32'(cnt) >= TIMEOUT_U) || (cnt == '1);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      match_cnt    <= '0;
      locked       <= 1'b0;
      err          <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      state        <= state_n;
      match_cnt    <= match_cnt_n;
      locked       <= locked_n;
      err          <= err_n;
      period       <= period_n;
      period_valid <= valid_n;
    end
  end

  always_comb begin
    state_n     = state;
    match_cnt_n = match_cnt;
    locked_n    = locked;
    err_n       = 1'b0;
    period_n    = period;
    valid_n     = 1'b0;
    case (state)
      IDLE: begin
        if (rise_int)
          state_n = MEASURE;
      end
      MEASURE: begin
        if (rise_int) begin
          period_n = cnt;
          valid_n  = 1'b1;
          if (match) begin
            match_cnt_n = match_cnt + MATCH_W'(1);
            if (match_cnt + MATCH_W'(1) == LOCK_TGT) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
            end
          end else begin
            match_cnt_n = '0;
          end
        end else if (timeout) begin
          state_n     = IDLE;
          match_cnt_n = '0;
        end
      end
      LOCKED: begin
        if (rise_int) begin
          period_n = cnt;
          valid_n  = 1'b1;
          if (!match) begin
            err_n       = 1'b1;
            locked_n    = 1'b0;
            match_cnt_n = '0;
            state_n     = MEASURE;
          end
        end else if (timeout) begin
          err_n       = 1'b1;
          locked_n    = 1'b0;
          match_cnt_n = '0;
          state_n     = IDLE;
        end
      end
      default: begin
        state_n     = IDLE;
        match_cnt_n = '0;
        locked_n    = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
// ----------------------------------------------------------------
// tb_clk_div_monitor: directed bench for clk_div_monitor
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_clk_div_monitor;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic div_in = 1'b0;

  always #5 clk_in = ~clk_in;

  // a: defaults, b: TOL=1, c: CNT_W=3 (timeout threshold beyond counter range)
  logic       a_rise, a_fall, a_valid, a_locked, a_err;
  logic [7:0] a_period;
  logic       b_rise, b_fall, b_valid, b_locked, b_err;
  logic [7:0] b_period;
  logic       c_rise, c_fall, c_valid, c_locked, c_err;
  logic [2:0] c_period;

  clk_div_monitor #(.CNT_W(8), .EXP_PERIOD(4), .TOL(0), .LOCK_CNT(4)) dut_a (
    .clk_in(clk_in), .rst_n(rst_n), .div_in(div_in),
    .rise_pulse(a_rise), .fall_pulse(a_fall), .period(a_period),
    .period_valid(a_valid), .locked(a_locked), .err(a_err)
  );

  clk_div_monitor #(.CNT_W(8), .EXP_PERIOD(4), .TOL(1), .LOCK_CNT(4)) dut_b (
    .clk_in(clk_in), .rst_n(rst_n), .div_in(div_in),
    .rise_pulse(b_rise), .fall_pulse(b_fall), .period(b_period),
    .period_valid(b_valid), .locked(b_locked), .err(b_err)
  );

  clk_div_monitor #(.CNT_W(3), .EXP_PERIOD(4), .TOL(0), .LOCK_CNT(4)) dut_c (
    .clk_in(clk_in), .rst_n(rst_n), .div_in(div_in),
    .rise_pulse(c_rise), .fall_pulse(c_fall), .period(c_period),
    .period_valid(c_valid), .locked(c_locked), .err(c_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v);
    div_in = v;
    @(posedge clk_in);
    #1;
  endtask

  // One slow-clock period: hi cycles high then lo low; checks the rise strobe
  // of this period, which publishes the length of the previous period.
  task automatic run_period(input int sel, input int hi, input int lo,
                            input logic exp_valid, input int exp_period,
                            input logic exp_locked, input logic exp_err,
                            input string tag);
    logic       rp, vp, lk, er;
    logic [7:0] pr;
    for (int i = 0; i < hi + lo; i++) begin
      cyc(i < hi);
      rp = (sel == 1) ? b_rise   : a_rise;
      vp = (sel == 1) ? b_valid  : a_valid;
      lk = (sel == 1) ? b_locked : a_locked;
      er = (sel == 1) ? b_err    : a_err;
      pr = (sel == 1) ? b_period : a_period;
      if (i == 2) begin
        chk({tag, ".rise"},   32'(rp), 32'(1'b1));
        chk({tag, ".valid"},  32'(vp), 32'(exp_valid));
        if (exp_valid)
          chk({tag, ".period"}, 32'(pr), 32'(exp_period));
        chk({tag, ".locked"}, 32'(lk), 32'(exp_locked));
        chk({tag, ".err"},    32'(er), 32'(exp_err));
      end
      if (i == 3) begin
        chk({tag, ".rise_off"},  32'(rp), 32'(1'b0));
        chk({tag, ".valid_off"}, 32'(vp), 32'(1'b0));
        chk({tag, ".err_off"},   32'(er), 32'(1'b0));
      end
    end
  endtask

  initial begin
    // Reset state
    rst_n  = 1'b0;
    div_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst.rise",   32'(a_rise),   0);
    chk("rst.fall",   32'(a_fall),   0);
    chk("rst.period", 32'(a_period), 0);
    chk("rst.valid",  32'(a_valid),  0);
    chk("rst.locked", 32'(a_locked), 0);
    chk("rst.err",    32'(a_err),    0);
    rst_n = 1'b1;
    repeat (3) cyc(1'b0);

    // Div-by-4: first rise unpublished, lock on the 4th published period
    for (int k = 0; k < 6; k++)
      run_period(0, 2, 2, (k >= 1), 4, (k >= 4), 1'b0, $sformatf("div4.%0d", k));

    // Stretched period of 6 breaks lock, then relock after 4 good periods
    run_period(0, 3, 3, 1'b1, 4, 1'b1, 1'b0, "stretch.pre");
    run_period(0, 2, 2, 1'b1, 6, 1'b0, 1'b1, "stretch.err");
    for (int k = 0; k < 4; k++)
      run_period(0, 2, 2, 1'b1, 4, (k == 3), 1'b0, $sformatf("relock.%0d", k));
    chk("c.locked_pre_stop", 32'(c_locked), 1);

    // Stopped clock: a times out at cnt 9, c at its saturated count 7
    run_period(0, 2, 2, 1'b1, 4, 1'b1, 1'b0, "stop.last");
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b0);
      chk($sformatf("stop.a.err.%0d", i),    32'(a_err),    32'(i == 8));
      chk($sformatf("stop.a.locked.%0d", i), 32'(a_locked), 32'(i < 8));
      chk($sformatf("stop.c.err.%0d", i),    32'(c_err),    32'(i == 6));
      chk($sformatf("stop.c.locked.%0d", i), 32'(c_locked), 32'(i < 6));
    end

    // Toggle every cycle from IDLE: alternating strobes, period 2, no lock
    for (int i = 0; i < 20; i++) begin
      cyc((i % 2) == 0);
      chk($sformatf("tog.rise.%0d", i),   32'(a_rise),   32'((i >= 2) && (i % 2 == 0)));
      chk($sformatf("tog.fall.%0d", i),   32'(a_fall),   32'((i >= 3) && (i % 2 == 1)));
      chk($sformatf("tog.valid.%0d", i),  32'(a_valid),  32'((i >= 4) && (i % 2 == 0)));
      if ((i >= 4) && (i % 2 == 0))
        chk($sformatf("tog.period.%0d", i), 32'(a_period), 2);
      chk($sformatf("tog.locked.%0d", i), 32'(a_locked), 0);
      chk($sformatf("tog.err.%0d", i),    32'(a_err),    0);
    end

    // TOL=1 with periods alternating 3 and 5
    rst_n = 1'b0;
    repeat (2) cyc(1'b0);
    rst_n = 1'b1;
    repeat (2) cyc(1'b0);
    run_period(1, 2, 1, 1'b0, 0, 1'b0, 1'b0, "tol.0");
    run_period(1, 3, 2, 1'b1, 3, 1'b0, 1'b0, "tol.1");
    run_period(1, 2, 1, 1'b1, 5, 1'b0, 1'b0, "tol.2");
    run_period(1, 3, 2, 1'b1, 3, 1'b0, 1'b0, "tol.3");
    run_period(1, 2, 1, 1'b1, 5, 1'b1, 1'b0, "tol.4");
    run_period(1, 3, 2, 1'b1, 3, 1'b1, 1'b0, "tol.5");

    // Asynchronous reset while locked, mid-strobe
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b0);
    chk("arst.pre_rise",   32'(b_rise),   1);
    chk("arst.pre_locked", 32'(b_locked), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.rise",   32'(b_rise),   0);
    chk("arst.fall",   32'(b_fall),   0);
    chk("arst.period", 32'(b_period), 0);
    chk("arst.valid",  32'(b_valid),  0);
    chk("arst.locked", 32'(b_locked), 0);
    chk("arst.err",    32'(b_err),    0);
    chk("arst.a_period", 32'(a_period), 0);
    repeat (2) cyc(1'b0);
    rst_n = 1'b1;
    repeat (2) cyc(1'b0);
    for (int k = 0; k < 5; k++)
      run_period(0, 2, 2, (k >= 1), 4, (k >= 4), 1'b0, $sformatf("after_rst.%0d", k));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
